// File: rtl/rc4_encrypt_fsm.sv
// RC4 encryptor: fills S with the identity, runs the 24-bit-key shuffle,
// then XORs MSG_LEN plaintext bytes with the keystream into the ciphertext
// RAM. S and plaintext memories have a two-cycle read latency, so every
// read is spread over RD / WAIT / LAT states.
module rc4_encrypt_fsm #(
   parameter int MSG_LEN = 32,
   parameter int MSG_AW  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [23:0]       secret_key,
   output logic [7:0]        s_address,
   output logic [7:0]        s_data,
   output logic              s_wren,
   input  logic [7:0]        s_q,
   output logic [MSG_AW-1:0] pt_address,
   input  logic [7:0]        pt_q,
   output logic [MSG_AW-1:0] ct_address,
   output logic [7:0]        ct_data,
   output logic              ct_wren,
   output logic              busy,
   output logic              done
);

   typedef enum logic [3:0] {
      IDLE, INIT, RDI, WAITI, LATI, RDJ, WAITJ, LATJ,
      WRI, WRJ, RDF, WAITF, WRCT, DONE
   } state_t;

   localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

   state_t            state, state_nx;
   logic              enc;      // 0: key-schedule shuffle, 1: keystream/encrypt phase
   logic [7:0]        i, j;
   logic [MSG_AW-1:0] k;
   logic [1:0]        km;       // i mod 3, tracked as a wrapping counter
   logic [7:0]        si, sj;
   logic [23:0]       key;

   function automatic logic [7:0] key_byte(input logic [23:0] kv, input logic [1:0] idx);
      case (idx)
         2'd0:    return kv[23:16];
         2'd1:    return kv[15:8];
         default: return kv[7:0];
      endcase
   endfunction

   // State register; reset aborts a run immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state and memory-port outputs, all zero unless a state drives them
   always_comb begin
      state_nx   = state;
      s_address  = '0;
      s_data     = '0;
      s_wren     = 1'b0;
      pt_address = '0;
      ct_address = '0;
      ct_data    = '0;
      ct_wren    = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = INIT;
         end
         INIT: begin
            s_address = i;
            s_data    = i;
            s_wren    = 1'b1;
            if (i == 8'hFF) state_nx = RDI;
         end
         RDI: begin
            // encrypt pre-increments i; the address leads the register by one
            s_address = enc ? i + 8'd1 : i;
            state_nx  = WAITI;
         end
         WAITI: begin
            s_address = i;
            state_nx  = LATI;
         end
         LATI: begin
            s_address = i;
            state_nx  = RDJ;
         end
         RDJ: begin
            s_address = j;
            state_nx  = WAITJ;
         end
         WAITJ: begin
            s_address = j;
            state_nx  = LATJ;
         end
         LATJ: begin
            s_address = j;
            state_nx  = WRI;
         end
         WRI: begin
            s_address = i;
            s_data    = sj;
            s_wren    = 1'b1;
            state_nx  = WRJ;
         end
         WRJ: begin
            s_address = j;
            s_data    = si;
            s_wren    = 1'b1;
            state_nx  = enc ? RDF : RDI;
         end
         RDF: begin
            s_address  = si + sj;
            pt_address = k;
            state_nx   = WAITF;
         end
         WAITF: begin
            s_address  = si + sj;
            pt_address = k;
            state_nx   = WRCT;
         end
         WRCT: begin
            ct_address = k;
            ct_data    = s_q ^ pt_q;
            ct_wren    = 1'b1;
            state_nx   = (k == K_LAST) ? DONE : RDI;
         end
         DONE: begin
            busy     = 1'b0;
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Index registers i, j, k and phase flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i   <= '0;
         j   <= '0;
         k   <= '0;
         km  <= '0;
         enc <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  i   <= '0;
                  j   <= '0;
                  k   <= '0;
                  km  <= '0;
                  enc <= 1'b0;
               end
            end
            INIT: begin
               i <= i + 8'd1;
               if (i == 8'hFF) begin
                  j  <= '0;
                  km <= '0;
               end
            end
            RDI: begin
               if (enc) i <= i + 8'd1;
            end
            LATI: begin
               j <= enc ? j + s_q : j + s_q + key_byte(key, km);
            end
            WRJ: begin
               if (!enc) begin
                  if (i == 8'hFF) begin
                     i   <= '0;
                     j   <= '0;
                     k   <= '0;
                     enc <= 1'b1;
                  end else begin
                     i  <= i + 8'd1;
                     km <= (km == 2'd2) ? 2'd0 : km + 2'd1;
                  end
               end
            end
            WRCT: begin
               if (k != K_LAST) k <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Key latch and swap operands; pure data, no reset needed
   always_ff @(posedge clk) begin
      if (state == IDLE && start) key <= secret_key;
      if (state == LATI) si <= s_q;
      if (state == LATJ) sj <= s_q;
   end

endmodule

// File: tb/tb_rc4_encrypt_fsm.sv
// Bench for rc4_encrypt_fsm: models the S / plaintext / ciphertext memories
// and compares ciphertext against a software RC4 reference.
module tb_rc4_encrypt_fsm;
   localparam int L = 32;
   localparam int LAT_EXP = 1 + 256 + 2048 + 11 * L;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  s_address, s_data, s_q;
   logic        s_wren;
   logic [4:0]  pt_address, ct_address;
   logic [7:0]  pt_q, ct_data;
   logic        ct_wren, busy, done;

   always #5 clk = ~clk;

   rc4_encrypt_fsm #(.MSG_LEN(L), .MSG_AW(5)) dut (
      .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
      .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
      .pt_address(pt_address), .pt_q(pt_q),
      .ct_address(ct_address), .ct_data(ct_data), .ct_wren(ct_wren),
      .busy(busy), .done(done)
   );

   logic [7:0] smem [256];
   logic [7:0] ptmem [L];
   logic [7:0] ctmem [L];
   logic [7:0] orig [L];
   logic [7:0] ref_ct [L];
   logic [7:0] s_addr_r, s_q_r, pt_q_r;
   logic [4:0] pt_addr_r;
   int cyc = 0, ct_wr_cnt = 0, done_cnt = 0, viol = 0;
   int n_chk = 0, n_fail = 0;
   logic [7:0] kv_exp [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

   assign s_q  = s_q_r;
   assign pt_q = pt_q_r;

   // memories with two-cycle read latency (registered address + registered data)
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (s_wren) smem[s_address] <= s_data;
      s_addr_r  <= s_address;
      s_q_r     <= smem[s_addr_r];
      pt_addr_r <= pt_address;
      pt_q_r    <= ptmem[pt_addr_r];
      if (ct_wren) begin
         ctmem[ct_address] <= ct_data;
         ct_wr_cnt <= ct_wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (s_wren && ct_wren) viol <= viol + 1;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {26'd0, s_address, s_data, s_wren, pt_address, ct_address, ct_data, ct_wren, busy, done};
   endfunction

   // Software RC4 with a 3-byte key over the current ptmem contents
   task automatic rc4_ref(input logic [23:0] key);
      int s [256];
      int kb [3];
      int ii, jj, t;
      kb[0] = int'(key[23:16]);
      kb[1] = int'(key[15:8]);
      kb[2] = int'(key[7:0]);
      for (int n = 0; n < 256; n++) s[n] = n;
      jj = 0;
      for (int n = 0; n < 256; n++) begin
         jj = (jj + s[n] + kb[n % 3]) % 256;
         t = s[n]; s[n] = s[jj]; s[jj] = t;
      end
      ii = 0; jj = 0;
      for (int m = 0; m < L; m++) begin
         ii = (ii + 1) % 256;
         jj = (jj + s[ii]) % 256;
         t = s[ii]; s[ii] = s[jj]; s[jj] = t;
         ref_ct[m] = ptmem[m] ^ 8'(s[(s[ii] + s[jj]) % 256]);
      end
   endtask

   task automatic clear_ct();
      for (int m = 0; m < L; m++) ctmem[m] = 8'h00;
   endtask

   task automatic check_ct(input string tag);
      for (int m = 0; m < L; m++) check_val($sformatf("%s[%0d]", tag, m), ctmem[m], ref_ct[m]);
   endtask

   task automatic load_known();
      string ps;
      ps = "Plaintext";
      for (int m = 0; m < L; m++) ptmem[m] = (m < 9) ? ps[m] : 8'($urandom_range(0, 255));
   endtask

   task automatic load_random();
      for (int m = 0; m < L; m++) ptmem[m] = 8'($urandom_range(0, 255));
   endtask

   // One encryption run; optional start pulse while busy and phase checks
   task automatic run_enc(input logic [23:0] key, input int pulse_at, input bit phase_chk);
      int acc, dn, d0, c0, bad;
      acc = -1; dn = -1;
      @(negedge clk);
      d0 = done_cnt; c0 = ct_wr_cnt;
      secret_key = key;
      start = 1'b1;
      for (int n = 0; n < 4 && acc < 0; n++) begin
         @(negedge clk);
         if (busy) acc = cyc;
      end
      start = 1'b0;
      check_val("accept", acc >= 0, 1);
      if (acc < 0) return;
      for (int n = 0; n < 3000 && dn < 0; n++) begin
         @(negedge clk);
         if (phase_chk && cyc - acc == 256) begin
            bad = 0;
            for (int a = 0; a < 256; a++) if (smem[a] !== 8'(a)) bad++;
            check_val("init_identity", bad, 0);
         end
         if (phase_chk && cyc - acc == 2304) check_val("no_ct_wren_before_enc", ct_wr_cnt - c0, 0);
         if (pulse_at > 0 && cyc - acc == pulse_at) start = 1'b1;
         else if (pulse_at > 0 && cyc - acc == pulse_at + 1) start = 1'b0;
         if (done) dn = cyc;
      end
      check_val("done_seen", dn >= 0, 1);
      // done is sampled high by the edge LAT_EXP edges after the accept edge
      check_val("latency", dn - acc + 1, LAT_EXP);
      repeat (3) @(negedge clk);
      check_val("done_pulses", done_cnt - d0, 1);
      check_val("ct_writes", ct_wr_cnt - c0, L);
   endtask

   initial begin
      int acc, a1, a2, d1, d2;
      logic [23:0] key;
      reset = 1'b1; start = 1'b0; secret_key = '0;
      for (int a = 0; a < 256; a++) smem[a] = 8'($urandom_range(0, 255));
      clear_ct();
      repeat (3) @(negedge clk);
      check_val("reset_outputs", all_outs(), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_val("idle_outputs", all_outs(), 64'd0);

      // known vector, with INIT / no-ct-write phase checks
      load_known();
      rc4_ref(24'h4B6579);
      run_enc(24'h4B6579, -1, 1'b1);
      for (int m = 0; m < 9; m++) check_val($sformatf("kv_const[%0d]", m), ctmem[m], kv_exp[m]);
      check_ct("kv_model");

      // all-zero key: first shuffle step has i == j == 0
      load_random(); clear_ct();
      rc4_ref(24'h000000);
      run_enc(24'h000000, -1, 1'b0);
      check_ct("zero_key");

      // round trip with "a".."z" + "aaaaaa"
      for (int m = 0; m < L; m++) begin
         ptmem[m] = (m < 26) ? 8'h61 + 8'(m) : 8'h61;
         orig[m]  = ptmem[m];
      end
      clear_ct();
      rc4_ref(24'h000249);
      run_enc(24'h000249, -1, 1'b0);
      check_ct("rt_enc");
      for (int m = 0; m < L; m++) ptmem[m] = ctmem[m];
      clear_ct();
      run_enc(24'h000249, -1, 1'b0);
      for (int m = 0; m < L; m++) check_val($sformatf("rt_dec[%0d]", m), ctmem[m], orig[m]);

      // random keys
      for (int r = 0; r < 2; r++) begin
         key = 24'($urandom);
         load_random(); clear_ct();
         rc4_ref(key);
         run_enc(key, -1, 1'b0);
         check_ct($sformatf("rand%0d", r));
      end

      // asynchronous reset in the middle of the shuffle
      acc = -1;
      @(negedge clk);
      secret_key = 24'h123456; start = 1'b1;
      for (int n = 0; n < 4 && acc < 0; n++) begin
         @(negedge clk);
         if (busy) acc = cyc;
      end
      start = 1'b0;
      check_val("mid_accept", acc >= 0, 1);
      for (int n = 0; n < 1100 && cyc - acc < 1000; n++) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_val("async_reset_outputs", all_outs(), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_val("after_reset_idle", all_outs(), 64'd0);
      load_known(); clear_ct();
      rc4_ref(24'h4B6579);
      run_enc(24'h4B6579, -1, 1'b0);
      for (int m = 0; m < 9; m++) check_val($sformatf("post_rst_kv[%0d]", m), ctmem[m], kv_exp[m]);
      check_ct("post_rst_model");

      // start pulsed while busy is ignored
      key = 24'($urandom);
      load_random(); clear_ct();
      rc4_ref(key);
      run_enc(key, 500, 1'b0);
      check_ct("pulse_busy");
      repeat (5) @(negedge clk);
      check_val("no_rerun", busy, 1'b0);

      // start held high: back-to-back runs
      key = 24'($urandom);
      load_random(); clear_ct();
      rc4_ref(key);
      a1 = -1; a2 = -1; d1 = -1; d2 = -1;
      @(negedge clk);
      secret_key = key; start = 1'b1;
      for (int n = 0; n < 4 && a1 < 0; n++) begin
         @(negedge clk);
         if (busy) a1 = cyc;
      end
      for (int n = 0; n < 3000 && d1 < 0; n++) begin
         @(negedge clk);
         if (done) d1 = cyc;
      end
      check_val("b2b_done1", d1 >= 0, 1);
      check_ct("b2b_run1");
      clear_ct();
      for (int n = 0; n < 10 && a2 < 0; n++) begin
         @(negedge clk);
         if (busy) a2 = cyc;
      end
      start = 1'b0;
      check_val("b2b_period", a2 - a1, 2658);
      for (int n = 0; n < 3000 && d2 < 0; n++) begin
         @(negedge clk);
         if (done) d2 = cyc;
      end
      check_val("b2b_done2", d2 >= 0, 1);
      repeat (3) @(negedge clk);
      check_ct("b2b_run2");

      check_val("wren_exclusive", viol, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
